// File: rtl/bpsk_pkg.sv
// Framing constants and receiver state type shared by the BPSK packet serializer and deserializer.
package bpsk_pkg;

  localparam int unsigned PACKET_SIZE = 184;
  localparam int unsigned SYNC_WIDTH  = 16;
  localparam logic [SYNC_WIDTH-1:0] SYNC_WORD = 16'h7E7E;
  localparam int unsigned BIT_CNT_W   = $clog2(PACKET_SIZE + 1);

  typedef enum logic {
    HUNT    = 1'b0,
    COLLECT = 1'b1
  } deser_state_t;

endpackage

// File: rtl/sync_detector.sv
// Serial sync-word hunter: shifts in enabled bits and flags the bit that completes PATTERN.
module sync_detector #(
  parameter int unsigned       WIDTH   = 16,
  parameter logic [WIDTH-1:0]  PATTERN = '0
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  input  logic bit_in,
  output logic match_c
);

  // The oldest history bit falls out on the matching shift, so WIDTH-1 flops suffice.
  logic [WIDTH-2:0] sr_q;
  logic [WIDTH-2:0] sr_d;
  logic [WIDTH-1:0] shifted_c;

  assign shifted_c = {sr_q, bit_in};
  assign match_c   = enable && (shifted_c == PATTERN);

  // A match empties the history so the next hunt starts from scratch.
  always_comb begin
    sr_d = sr_q;
    if (clear) begin
      sr_d = '0;
    end else if (match_c) begin
      sr_d = '0;
    end else if (enable) begin
      sr_d = shifted_c[WIDTH-2:0];
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

endmodule

// File: rtl/packet_deserializer.sv
// Receive-side packet framer: hunts for the sync word, collects a payload MSB-first and
// hands it to the consumer through a holding register with a valid/ack handshake.
module packet_deserializer
  import bpsk_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   bit_in,
  input  logic                   bit_valid,
  input  logic                   clear,
  output logic [PACKET_SIZE-1:0] packet_out,
  output logic                   packet_valid,
  input  logic                   packet_ack,
  output logic                   locked,
  output logic [BIT_CNT_W-1:0]   bit_count,
  output logic                   sync_lost,
  output logic                   overrun
);

  localparam int unsigned IDLE_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [IDLE_W-1:0]    IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);
  localparam logic [BIT_CNT_W-1:0] CNT_LAST  = BIT_CNT_W'(PACKET_SIZE - 1);

  deser_state_t           state_q, state_d;
  logic [PACKET_SIZE-2:0] data_sr_q, data_sr_d;
  logic [BIT_CNT_W-1:0]   bit_count_q, bit_count_d;
  logic [IDLE_W-1:0]      idle_cnt_q, idle_cnt_d;
  logic [PACKET_SIZE-1:0] pkt_q, pkt_d;
  logic                   pkt_valid_q, pkt_valid_d;
  logic                   sync_lost_q, sync_lost_d;
  logic                   overrun_q, overrun_d;

  logic                   sync_en_c;
  logic                   sync_match_c;
  logic [PACKET_SIZE-1:0] new_pkt_c;

  assign sync_en_c = (state_q == HUNT) && bit_valid && !clear;
  assign new_pkt_c = {data_sr_q, bit_in};

  sync_detector #(
    .WIDTH   (SYNC_WIDTH),
    .PATTERN (SYNC_WORD)
  ) u_sync_detector (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (clear),
    .enable  (sync_en_c),
    .bit_in  (bit_in),
    .match_c (sync_match_c)
  );

  // Next-state: framing FSM, payload shifter, idle timeout and holding-register handshake.
  always_comb begin
    state_d     = state_q;
    data_sr_d   = data_sr_q;
    bit_count_d = bit_count_q;
    idle_cnt_d  = idle_cnt_q;
    pkt_d       = pkt_q;
    pkt_valid_d = pkt_valid_q;
    sync_lost_d = 1'b0;
    overrun_d   = 1'b0;

    if (pkt_valid_q && packet_ack) begin
      pkt_valid_d = 1'b0;
    end

    if (clear) begin
      state_d     = HUNT;
      data_sr_d   = '0;
      bit_count_d = '0;
      idle_cnt_d  = '0;
    end else begin
      case (state_q)
        HUNT: begin
          if (sync_match_c) begin
            state_d     = COLLECT;
            bit_count_d = '0;
            idle_cnt_d  = '0;
          end
        end
        COLLECT: begin
          if (bit_valid) begin
            idle_cnt_d = '0;
            if (bit_count_q == CNT_LAST) begin
              state_d     = HUNT;
              bit_count_d = '0;
              data_sr_d   = '0;
              // A same-cycle ack frees the holding register for the new packet.
              if (!pkt_valid_q || packet_ack) begin
                pkt_d       = new_pkt_c;
                pkt_valid_d = 1'b1;
              end else begin
                overrun_d = 1'b1;
              end
            end else begin
              data_sr_d   = new_pkt_c[PACKET_SIZE-2:0];
              bit_count_d = bit_count_q + BIT_CNT_W'(1);
            end
          end else if (idle_cnt_q == IDLE_LAST) begin
            state_d     = HUNT;
            bit_count_d = '0;
            data_sr_d   = '0;
            idle_cnt_d  = '0;
            sync_lost_d = 1'b1;
          end else begin
            idle_cnt_d = idle_cnt_q + IDLE_W'(1);
          end
        end
        default: begin
          state_d = HUNT;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= HUNT;
      data_sr_q   <= '0;
      bit_count_q <= '0;
      idle_cnt_q  <= '0;
      pkt_q       <= '0;
      pkt_valid_q <= 1'b0;
      sync_lost_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      data_sr_q   <= data_sr_d;
      bit_count_q <= bit_count_d;
      idle_cnt_q  <= idle_cnt_d;
      pkt_q       <= pkt_d;
      pkt_valid_q <= pkt_valid_d;
      sync_lost_q <= sync_lost_d;
      overrun_q   <= overrun_d;
    end
  end

  assign packet_out   = pkt_q;
  assign packet_valid = pkt_valid_q;
  assign locked       = (state_q == COLLECT);
  assign bit_count    = bit_count_q;
  assign sync_lost    = sync_lost_q;
  assign overrun      = overrun_q;

endmodule
